sumador_serie: RTL and testbench
================================

SUMADOR_SERIE -- requirements
Module: sumador_serie

Interface
REQ-001 Parameter: N, default 8, operand width in bits; legal range 2..32.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  request to add a and b; sampled on rising edge.
REQ-005 a  input  N  operand A; sampled only on the edge that accepts start.
REQ-006 b  input  N  operand B; sampled only on the edge that accepts start.
REQ-007 s  output  N  registered sum of the last completed operation.
REQ-008 cout  output  1  registered carry-out of the last completed operation.
REQ-009 busy  output  1  high while an operation is in progress (state SUMA).
REQ-010 done  output  1  one-cycle completion pulse (state FIN).

Function
REQ-011 The block SHALL be a bit-serial adder: one half-adder pair plus a carry flip-flop (full-adder cell), LSB first, one bit per clock.
REQ-012 The FSM SHALL have exactly three states: IDLE, SUMA, FIN.
REQ-013 In IDLE with start=1, the edge SHALL load a and b into shift registers, clear the carry flip-flop, clear the bit counter, and enter SUMA.
REQ-014 In IDLE with start=0, the FSM SHALL remain in IDLE with s and cout held.
REQ-015 In SUMA, each edge SHALL compute bit = a_sh[0]^b_sh[0]^c and c_next = majority(a_sh[0], b_sh[0], c).
REQ-016 Each SUMA edge SHALL also shift bit into the internal sum register from the MSB, shift a_sh and b_sh right by one, and increment the counter.
REQ-017 On the Nth SUMA edge (counter = N-1), s SHALL be loaded with the complete sum, cout with c_next, and the FSM SHALL enter FIN.
REQ-018 s and cout SHALL not change at any time other than REQ-017 and reset; intermediate shift values are never visible on s.
REQ-019 FIN SHALL last exactly one cycle and then return unconditionally to IDLE.
REQ-020 busy SHALL equal (state==SUMA); done SHALL equal (state==FIN); both are decoded from the state register only.
REQ-021 Latency: when start is accepted on edge E0, done SHALL be high from edge E(N) to edge E(N+1), and busy SHALL be high from E0 to E(N).
REQ-022 start SHALL be ignored in SUMA and FIN; it is not queued.
REQ-023 Changes to a or b after acceptance SHALL not affect the operation in progress.
REQ-024 Arithmetic: {cout,s} SHALL equal a+b as an unsigned (N+1)-bit sum; wrap-around of s is modulo 2^N, with overflow reported only on cout.
REQ-025 Back-to-back operation: start held high continuously SHALL be accepted on the IDLE edge after each FIN, giving one result every N+2 cycles.

Reset
REQ-026 With rst=1 on a rising edge, the FSM SHALL enter IDLE and s, cout, carry, counter, and shift registers SHALL become 0, so busy=0 and done=0.
REQ-027 rst SHALL take priority over start and over any in-progress operation; an aborted operation SHALL produce no done pulse and leave s=0 and cout=0.
REQ-028 The first start SHALL be accepted on the first edge with rst=0.

Verification
REQ-029 N=8, a=0x0F, b=0x01, start pulse: busy high for 8 cycles, then a single done pulse with s=0x10 and cout=0.
REQ-030 N=8, a=0xFF, b=0x01: s=0x00, cout=1 at done (full carry ripple and wrap-around).
REQ-031 N=8, a=0xFF, b=0xFF: s=0xFE, cout=1; then a=0x00, b=0x00: s=0x00, cout=0, and s stays 0xFE until that second done.
REQ-032 Start pulse and operand change 3 cycles into SUMA (a=0x55, b=0xAA, then a=b=0x00): the second start is ignored and the result is s=0xFF, cout=0, with exactly one done pulse.
REQ-033 rst asserted on the 4th SUMA cycle: next cycle IDLE with busy=0, done=0, s=0x00, cout=0, and no done pulse appears afterwards.
REQ-034 start held high for 3 operations with random a and b: done pulses every 10 cycles, each {cout,s} equal to a+b.

Source files
------------

// File: rtl/sumador_serie.sv
// Bit-serial unsigned adder: one full-adder cell (two half adders plus a carry
// flop) consumes one operand bit per clock, LSB first, and publishes {cout,s}.
module sumador_serie #(
    parameter int unsigned N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] s,
    output logic         cout,
    output logic         busy,
    output logic         done
);

    localparam int unsigned CW = $clog2(N);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUMA = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [N-1:0]    a_sh_q, a_sh_d;
    logic [N-1:0]    b_sh_q, b_sh_d;
    logic [N-2:0]    sum_sh_q, sum_sh_d;
    logic            c_q, c_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [N-1:0]    s_q, s_d;
    logic            cout_q, cout_d;

    logic            ha1_s, ha1_c, ha2_s, ha2_c;
    logic            c_next;
    logic [N-1:0]    sum_full;

    // Full-adder cell built from two half adders.
    always_comb begin
        ha1_s  = a_sh_q[0] ^ b_sh_q[0];
        ha1_c  = a_sh_q[0] & b_sh_q[0];
        ha2_s  = ha1_s ^ c_q;
        ha2_c  = ha1_s & c_q;
        c_next = ha1_c | ha2_c;
        // New sum bit enters from the MSB; after N shifts the LSB lands at bit 0.
        sum_full = {ha2_s, sum_sh_q};
    end

    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        sum_sh_d = sum_sh_q;
        c_d      = c_q;
        cnt_d    = cnt_q;
        s_d      = s_q;
        cout_d   = cout_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    c_d     = 1'b0;
                    cnt_d   = '0;
                    state_d = SUMA;
                end
            end
            SUMA: begin
                sum_sh_d = sum_full[N-1:1];
                a_sh_d   = a_sh_q >> 1;
                b_sh_d   = b_sh_q >> 1;
                c_d      = c_next;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == CW'(N - 1)) begin
                    s_d     = sum_full;
                    cout_d  = c_next;
                    state_d = FIN;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            sum_sh_q <= '0;
            c_q      <= 1'b0;
            cnt_q    <= '0;
            s_q      <= '0;
            cout_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            sum_sh_q <= sum_sh_d;
            c_q      <= c_d;
            cnt_q    <= cnt_d;
            s_q      <= s_d;
            cout_q   <= cout_d;
        end
    end

    assign s    = s_q;
    assign cout = cout_q;
    assign busy = (state_q == SUMA);
    assign done = (state_q == FIN);

endmodule

// File: tb/tb_sumador_serie.sv
// Directed self-checking bench for sumador_serie with N=8.
module tb_sumador_serie;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] s;
    logic       cout;
    logic       busy;
    logic       done;

    int passed = 0;
    int total  = 0;

    sumador_serie #(.N(8)) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .a    (a),
        .b    (b),
        .s    (s),
        .cout (cout),
        .busy (busy),
        .done (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one operation and observe it up to the done cycle; no checking here.
    task automatic do_op(input logic [7:0] ia, input logic [7:0] ib,
                         output logic [7:0] os, output logic oc,
                         output int nbusy, output int ncyc, output bit s_moved);
        logic [7:0] s0;
        logic       c0;
        s0 = s; c0 = cout; nbusy = 0; ncyc = 0; s_moved = 0;
        a = ia; b = ib; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (done !== 1'b1 && ncyc < 40) begin
            if (busy === 1'b1) nbusy++;
            if (s !== s0 || cout !== c0) s_moved = 1;
            ncyc++;
            @(negedge clk);
        end
        os = s; oc = cout;
    endtask

    task automatic test_reset();
        int n;
        rst = 1'b1; start = 1'b0; a = 8'h00; b = 8'h00;
        repeat (2) @(negedge clk);
        total++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL reset_flags: busy=%b done=%b exp 0 0", busy, done); else passed++;
        total++; if (s !== 8'h00 || cout !== 1'b0) $display("FAIL reset_sum: s=%h cout=%b exp 00 0", s, cout); else passed++;
        // first start accepted on the first edge with rst low
        rst = 1'b0; start = 1'b1; a = 8'h03; b = 8'h04;
        @(negedge clk);
        start = 1'b0;
        total++; if (busy !== 1'b1) $display("FAIL first_start: busy=%b exp 1", busy); else passed++;
        n = 0;
        while (done !== 1'b1 && n < 40) begin n++; @(negedge clk); end
        total++; if (s !== 8'h07 || cout !== 1'b0) $display("FAIL first_sum: s=%h cout=%b exp 07 0", s, cout); else passed++;
        @(negedge clk);
    endtask

    task automatic test_basic();
        logic [7:0] os; logic oc; int nb, nc; bit mv;
        do_op(8'h0F, 8'h01, os, oc, nb, nc, mv);
        total++; if (nc !== 8) $display("FAIL basic_latency: cycles=%0d exp 8", nc); else passed++;
        total++; if (nb !== 8) $display("FAIL basic_busy: busy_cycles=%0d exp 8", nb); else passed++;
        total++; if (os !== 8'h10 || oc !== 1'b0) $display("FAIL basic_sum: s=%h cout=%b exp 10 0", os, oc); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL basic_busy_at_done: busy=%b exp 0", busy); else passed++;
        @(negedge clk);
        total++; if (done !== 1'b0 || busy !== 1'b0) $display("FAIL basic_done_pulse: done=%b busy=%b exp 0 0", done, busy); else passed++;
        total++; if (s !== 8'h10) $display("FAIL basic_hold: s=%h exp 10", s); else passed++;
    endtask

    task automatic test_carry();
        logic [7:0] os; logic oc; int nb, nc; bit mv;
        do_op(8'hFF, 8'h01, os, oc, nb, nc, mv);
        total++; if (os !== 8'h00 || oc !== 1'b1) $display("FAIL carry_ripple: s=%h cout=%b exp 00 1", os, oc); else passed++;
        @(negedge clk);
    endtask

    task automatic test_hold();
        logic [7:0] os; logic oc; int nb, nc; bit mv;
        do_op(8'hFF, 8'hFF, os, oc, nb, nc, mv);
        total++; if (os !== 8'hFE || oc !== 1'b1) $display("FAIL hold_first: s=%h cout=%b exp fe 1", os, oc); else passed++;
        @(negedge clk);
        do_op(8'h00, 8'h00, os, oc, nb, nc, mv);
        total++; if (mv !== 1'b0) $display("FAIL hold_stable: s_moved=%b exp 0", mv); else passed++;
        total++; if (os !== 8'h00 || oc !== 1'b0) $display("FAIL hold_second: s=%h cout=%b exp 00 0", os, oc); else passed++;
        @(negedge clk);
    endtask

    task automatic test_ignore_start();
        int ndone;
        logic [7:0] ds; logic dc;
        ndone = 0; ds = 8'hxx; dc = 1'bx;
        a = 8'h55; b = 8'hAA; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        a = 8'h00; b = 8'h00; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (done === 1'b1) begin ndone++; ds = s; dc = cout; end
            @(negedge clk);
        end
        total++; if (ndone !== 1) $display("FAIL ignore_pulses: done_count=%0d exp 1", ndone); else passed++;
        total++; if (ds !== 8'hFF || dc !== 1'b0) $display("FAIL ignore_sum: s=%h cout=%b exp ff 0", ds, dc); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL ignore_idle: busy=%b exp 0", busy); else passed++;
    endtask

    task automatic test_reset_abort();
        int ndone;
        ndone = 0;
        a = 8'hFF; b = 8'h01; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL abort_flags: busy=%b done=%b exp 0 0", busy, done); else passed++;
        total++; if (s !== 8'h00 || cout !== 1'b0) $display("FAIL abort_sum: s=%h cout=%b exp 00 0", s, cout); else passed++;
        for (int i = 0; i < 15; i++) begin
            if (done === 1'b1) ndone++;
            @(negedge clk);
        end
        total++; if (ndone !== 0) $display("FAIL abort_no_done: done_count=%0d exp 0", ndone); else passed++;
    endtask

    task automatic test_back_to_back();
        logic [7:0] va [3];
        logic [7:0] vb [3];
        logic [7:0] es [3];
        logic       ec [3];
        int cyc, last, idx;
        va[0] = 8'hA5; vb[0] = 8'h5A; es[0] = 8'hFF; ec[0] = 1'b0;
        va[1] = 8'h80; vb[1] = 8'h80; es[1] = 8'h00; ec[1] = 1'b1;
        va[2] = 8'h7F; vb[2] = 8'h3C; es[2] = 8'hBB; ec[2] = 1'b0;
        cyc = 0; last = 0; idx = 0;
        a = va[0]; b = vb[0]; start = 1'b1;
        while (idx < 3 && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (done === 1'b1) begin
                total++; if (s !== es[idx] || cout !== ec[idx]) $display("FAIL b2b_sum%0d: s=%h cout=%b exp %h %b", idx, s, cout, es[idx], ec[idx]); else passed++;
                if (idx > 0) begin
                    total++; if (cyc - last !== 10) $display("FAIL b2b_period%0d: cycles=%0d exp 10", idx, cyc - last); else passed++;
                end
                last = cyc;
                idx++;
                if (idx < 3) begin a = va[idx]; b = vb[idx]; end
            end
        end
        start = 1'b0;
        total++; if (idx !== 3) $display("FAIL b2b_count: results=%0d exp 3", idx); else passed++;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_carry();
        test_hold();
        test_ignore_start();
        test_reset_abort();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
